regfile_wb_scheduler: RTL



---
 rtl/regfile_wb_scheduler.sv | 97 +++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the integer register file: round-robin arbitration of
// ALU and load writebacks onto the single write port, plus a pending-write scoreboard.
module regfile_wb_scheduler #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_rd_index,
  input  logic [XLEN-1:0]              alu_rd,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_rd_index,
  input  logic [XLEN-1:0]              mem_rd,
  output logic                         mem_ready,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rs1_index,
  input  logic [ADDR_WIDTH-1:0]        issue_rs2_index,
  input  logic [ADDR_WIDTH-1:0]        issue_rd_index,
  input  logic                         issue_uses_rd,
  output logic                         issue_stall,
  input  logic                         flush,
  output logic                         rf_write_en,
  output logic [ADDR_WIDTH-1:0]        rf_rd_index,
  output logic [XLEN-1:0]              rf_rd,
  output logic [(2**ADDR_WIDTH)-1:0]   pending
);

  localparam int NREGS = 2**ADDR_WIDTH;

  logic                  r_last_grant_mem;
  logic                  r_rf_write_en;
  logic [ADDR_WIDTH-1:0] r_rf_rd_index;
  logic [XLEN-1:0]       r_rf_rd;
  logic [NREGS-1:0]      r_pending;

  logic                  w_grant_alu;
  logic                  w_grant_mem;
  logic                  w_handshake;
  logic [ADDR_WIDTH-1:0] w_wb_index;
  logic [XLEN-1:0]       w_wb_data;
  logic                  w_hazard;
  logic                  w_issue_set;
  logic [NREGS-1:0]      w_pending_next;

  // On contention the requester that did not win last time gets the port.
  assign w_grant_alu = alu_valid & (~mem_valid | r_last_grant_mem);
  assign w_grant_mem = mem_valid & (~alu_valid | ~r_last_grant_mem);
  assign w_handshake = w_grant_alu | w_grant_mem;
  assign w_wb_index  = w_grant_alu ? alu_rd_index : mem_rd_index;
  assign w_wb_data   = w_grant_alu ? alu_rd : mem_rd;

  assign alu_ready = w_grant_alu;
  assign mem_ready = w_grant_mem;

  // No bypass: a consumer waits until the producing write has been registered.
  assign w_hazard    = r_pending[issue_rs1_index] | r_pending[issue_rs2_index]
                     | (issue_uses_rd & r_pending[issue_rd_index]);
  assign issue_stall = issue_valid & w_hazard;
  assign w_issue_set = issue_valid & ~w_hazard & issue_uses_rd
                     & (issue_rd_index != '0);

  always_comb begin
    // NOTE: default assignment first so every path assigns the vector and no latch is inferred.
    w_pending_next = r_pending;
    if (w_handshake) w_pending_next[w_wb_index] = 1'b0;
    if (w_issue_set) w_pending_next[issue_rd_index] = 1'b1;
    if (flush)       w_pending_next = '0;
    w_pending_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant_mem <= 1'b1;
      r_rf_write_en    <= 1'b0;
      r_rf_rd_index    <= '0;
      r_rf_rd          <= '0;
      r_pending        <= '0;
    end else begin
      r_rf_write_en <= w_handshake & (w_wb_index != '0);
      if (w_handshake) begin
        r_last_grant_mem <= w_grant_mem;
        r_rf_rd_index    <= w_wb_index;
        r_rf_rd          <= w_wb_data;
      end
      r_pending <= w_pending_next;
    end
  end

  assign rf_write_en = r_rf_write_en;
  assign rf_rd_index = r_rf_rd_index;
  assign rf_rd       = r_rf_rd;
  assign pending     = r_pending;

endmodule
